// File: rtl/div_seq_ctrl_if.sv
// Request/response handshake between the M-extension front end and the divide sequencer.
// The master drives requests and consumes results; the slave is the sequencer.
interface div_seq_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [XLEN-1:0] req_opr1;
    logic [XLEN-1:0] req_opr2;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;

    modport master (
        output req_valid,
        output req_op,
        output req_opr1,
        output req_opr2,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_result
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_opr1,
        input  req_opr2,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_result
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequencer for DIV/DIVU/REM/REMU around an iterative unsigned divider core: sign handling,
// RISC-V corner cases, start pulse, result hold, and flush draining of an in-flight divide.
module div_seq_ctrl #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    div_seq_ctrl_if.slave   bus,
    output logic            busy_o,
    output logic            div_start_o,
    output logic [XLEN-1:0] div_opr1_o,
    output logic [XLEN-1:0] div_opr2_o,
    input  logic            div_done_i,
    input  logic [XLEN-1:0] div_quo_i,
    input  logic [XLEN-1:0] div_rem_i
);
    localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDrain, StResp} state_e;

    state_e          state_q;
    logic            resp_valid_q;
    logic            div_start_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] opr1_q;
    logic [XLEN-1:0] opr2_q;
    logic            is_rem_q;
    logic            neg_res_q;

    // Request decode: op[0] set means unsigned, op[1] set means remainder.
    logic            req_signed;
    logic            req_rem;
    logic            sign1;
    logic            sign2;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            div_zero;
    logic            overflow;
    logic            accept;
    logic [XLEN-1:0] core_res;
    logic [XLEN-1:0] core_res_fixed;

    always_comb begin
        req_signed     = ~bus.req_op[0];
        req_rem        = bus.req_op[1];
        sign1          = req_signed & bus.req_opr1[XLEN-1];
        sign2          = req_signed & bus.req_opr2[XLEN-1];
        mag1           = sign1 ? (~bus.req_opr1 + 1'b1) : bus.req_opr1;
        mag2           = sign2 ? (~bus.req_opr2 + 1'b1) : bus.req_opr2;
        div_zero       = (bus.req_opr2 == '0);
        overflow       = req_signed && (bus.req_opr1 == MinVal) && (bus.req_opr2 == '1);
        accept         = bus.req_valid && bus.req_ready;
        core_res       = is_rem_q ? div_rem_i : div_quo_i;
        core_res_fixed = neg_res_q ? (~core_res + 1'b1) : core_res;
    end

    assign bus.req_ready   = (state_q == StIdle) && !flush_i;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_result = result_q;
    assign busy_o          = (state_q != StIdle);
    assign div_start_o     = div_start_q;
    assign div_opr1_o      = opr1_q;
    assign div_opr2_o      = opr2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            div_start_q  <= 1'b0;
            result_q     <= '0;
            opr1_q       <= '0;
            opr2_q       <= '0;
            is_rem_q     <= 1'b0;
            neg_res_q    <= 1'b0;
        end else begin
            div_start_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        opr1_q    <= mag1;
                        opr2_q    <= mag2;
                        is_rem_q  <= req_rem;
                        neg_res_q <= req_rem ? sign1 : (sign1 ^ sign2);
                        if (div_zero) begin
                            result_q     <= req_rem ? bus.req_opr1 : '1;
                            resp_valid_q <= 1'b1;
                            state_q      <= StResp;
                        end else if (overflow) begin
                            result_q     <= req_rem ? '0 : bus.req_opr1;
                            resp_valid_q <= 1'b1;
                            state_q      <= StResp;
                        end else begin
                            div_start_q <= 1'b1;
                            state_q     <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    // The core cannot be aborted, so a flush must wait for its done pulse.
                    if (flush_i) begin
                        state_q <= div_done_i ? StIdle : StDrain;
                    end else if (div_done_i) begin
                        result_q     <= core_res_fixed;
                        resp_valid_q <= 1'b1;
                        state_q      <= StResp;
                    end
                end
                StDrain: begin
                    if (div_done_i) begin
                        state_q <= StIdle;
                    end
                end
                StResp: begin
                    if (flush_i || bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= StIdle;
                end
            endcase
        end
    end
endmodule
